// File: rtl/alu.sv
// Dot-product ALU: out = row0*col0 + row1*col1 on unsigned 8-bit operands.
// Flow is IDLE -> MULT -> ADD -> DONE. The result appears two cycles after the
// edge that samples start, and is held in DONE until the next start.
// Build option: define ALU_DADDA_EN to build each product from an explicit
// Dadda-tree multiplier (mult_inst1, mult_inst2) instead of the '*' operator.
// Results and cycle timing are the same in both builds.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  row0,
  input  logic [7:0]  row1,
  input  logic [7:0]  col0,
  input  logic [7:0]  col1,
  output logic [17:0] out,
  output logic        complete
);

  typedef enum logic [1:0] {StIdle, StMult, StAdd, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a0_reg, a1_reg, b0_reg, b1_reg;
  logic [7:0]  a0_d, a1_d, b0_d, b1_d;
  logic [15:0] mult_out_1, mult_out_2;
  logic [15:0] mult_1_d, mult_2_d;
  logic [15:0] p1, p2;
  logic [17:0] o;
  logic [17:0] out_q, out_d;
  logic        complete_q, complete_d;

`ifdef ALU_DADDA_EN
  // Dadda reduction of an 8x8 AND array through heights 6,4,3,2.
  // Returns the two final rows as {row1, row0}; their sum is the product.
  function automatic logic [31:0] dadda8(input logic [7:0] a, input logic [7:0] b);
    logic        col  [16][10];
    logic        ncol [16][10];
    int          cnt  [16];
    int          ncnt [16];
    int          h, idx, d;
    logic        x, y, z;
    logic [15:0] r0, r1;
    for (int c = 0; c < 16; c++) begin
      cnt[c] = 0;
      for (int k = 0; k < 10; k++) col[c][k] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[i+j][cnt[i+j]] = a[i] & b[j];
        cnt[i+j]++;
      end
    end
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       d = 6;
        1:       d = 4;
        2:       d = 3;
        default: d = 2;
      endcase
      for (int c = 0; c < 16; c++) begin
        ncnt[c] = 0;
        for (int k = 0; k < 10; k++) ncol[c][k] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
        idx = 0;
        // Carries already pushed into this column count toward its height.
        h = cnt[c] + ncnt[c];
        for (int k = 0; k < 8; k++) begin
          if (h > d) begin
            x = col[c][idx];
            y = col[c][idx+1];
            if (h == d + 1) begin
              ncol[c][ncnt[c]] = x ^ y;
              ncnt[c]++;
              if (c < 15) begin
                ncol[c+1][ncnt[c+1]] = x & y;
                ncnt[c+1]++;
              end
              idx = idx + 2;
              h   = h - 1;
            end else begin
              z = col[c][idx+2];
              ncol[c][ncnt[c]] = x ^ y ^ z;
              ncnt[c]++;
              if (c < 15) begin
                ncol[c+1][ncnt[c+1]] = (x & y) | (x & z) | (y & z);
                ncnt[c+1]++;
              end
              idx = idx + 3;
              h   = h - 2;
            end
          end
        end
        for (int k = 0; k < 10; k++) begin
          if (k >= idx && k < cnt[c]) begin
            ncol[c][ncnt[c]] = col[c][k];
            ncnt[c]++;
          end
        end
      end
      for (int c = 0; c < 16; c++) begin
        cnt[c] = ncnt[c];
        for (int k = 0; k < 10; k++) col[c][k] = ncol[c][k];
      end
    end
    for (int c = 0; c < 16; c++) begin
      r0[c] = (cnt[c] > 0) ? col[c][0] : 1'b0;
      r1[c] = (cnt[c] > 1) ? col[c][1] : 1'b0;
    end
    return {r1, r0};
  endfunction

  if (1'b1) begin : mult_inst1
    logic [31:0] rows;
    logic [15:0] PRE [2];
    assign rows   = dadda8(a0_reg, b0_reg);
    assign PRE[0] = rows[15:0];
    assign PRE[1] = rows[31:16];
    assign p1     = PRE[0] + PRE[1];
  end

  if (1'b1) begin : mult_inst2
    logic [31:0] rows;
    logic [15:0] PRE [2];
    assign rows   = dadda8(a1_reg, b1_reg);
    assign PRE[0] = rows[15:0];
    assign PRE[1] = rows[31:16];
    assign p2     = PRE[0] + PRE[1];
  end
`else
  assign p1 = a0_reg * b0_reg;
  assign p2 = a1_reg * b1_reg;
`endif

  // Adder sum; cannot overflow 17 bits, so bit 17 stays 0.
  assign o = {2'b00, mult_out_1} + {2'b00, mult_out_2};

  // Next-state, operand capture and result update.
  always_comb begin
    state_d    = state_q;
    a0_d       = a0_reg;
    a1_d       = a1_reg;
    b0_d       = b0_reg;
    b1_d       = b1_reg;
    mult_1_d   = mult_out_1;
    mult_2_d   = mult_out_2;
    out_d      = out_q;
    complete_d = complete_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a0_d       = row0;
          a1_d       = row1;
          b0_d       = col0;
          b1_d       = col1;
          complete_d = 1'b0;
          state_d    = StMult;
        end
      end
      StMult: begin
        mult_1_d = p1;
        mult_2_d = p2;
        state_d  = StAdd;
      end
      StAdd: begin
        out_d      = o;
        complete_d = 1'b1;
        state_d    = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      a0_reg     <= '0;
      a1_reg     <= '0;
      b0_reg     <= '0;
      b1_reg     <= '0;
      mult_out_1 <= '0;
      mult_out_2 <= '0;
      out_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a0_reg     <= a0_d;
      a1_reg     <= a1_d;
      b0_reg     <= b0_d;
      b1_reg     <= b1_d;
      mult_out_1 <= mult_1_d;
      mult_out_2 <= mult_2_d;
      out_q      <= out_d;
      complete_q <= complete_d;
    end
  end

  assign out      = out_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors plus random operands,
// compared against a plain-arithmetic dot-product model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  row0, row1, col0, col1;
  logic [17:0] out;
  logic        complete;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row0     (row0),
    .row1     (row1),
    .col0     (col0),
    .col1     (col1),
    .out      (out),
    .complete (complete)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int dot(input int r0, input int r1, input int c0, input int c1);
    return r0 * c0 + r1 * c1;
  endfunction

  task automatic scramble_inputs();
    row0 = 8'($urandom);
    row1 = 8'($urandom);
    col0 = 8'($urandom);
    col1 = 8'($urandom);
  endtask

  // One operation; with noise set, start toggles randomly while busy and must be ignored.
  task automatic run_op(input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] c0, input logic [7:0] c1, input bit noise);
    int exp_v;
    exp_v = dot(int'(r0), int'(r1), int'(c0), int'(c1));
    @(negedge clk);
    start = 1'b1;
    row0 = r0; row1 = r1; col0 = c0; col1 = c1;
    @(negedge clk);
    check_eq("complete_cleared", 32'(complete), 32'd0);
    start = noise ? 1'($urandom) : 1'b0;
    scramble_inputs();
    @(negedge clk);
    check_eq("complete_busy", 32'(complete), 32'd0);
    start = noise ? 1'($urandom) : 1'b0;
    scramble_inputs();
    @(negedge clk);
    start = 1'b0;
    check_eq("result", 32'(out), 32'(exp_v));
    check_eq("complete_set", 32'(complete), 32'd1);
    @(negedge clk);
    check_eq("result_hold", 32'(out), 32'(exp_v));
    check_eq("complete_hold", 32'(complete), 32'd1);
  endtask

  initial begin
    logic [7:0] v [4];
    rst   = 1'b0;
    start = 1'b0;
    row0 = 8'h00; row1 = 8'h00; col0 = 8'h00; col1 = 8'h00;
    #12;
    check_eq("reset_out", 32'(out), 32'd0);
    check_eq("reset_complete", 32'(complete), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_complete", 32'(complete), 32'd0);

    run_op(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    run_op(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    check_eq("const_11", 32'(out), 32'd11);
    run_op(8'hFF, 8'h00, 8'h01, 8'h02, 1'b0);
    check_eq("const_255", 32'(out), 32'd255);
    run_op(8'h10, 8'h20, 8'h02, 8'h03, 1'b1);
    check_eq("const_128", 32'(out), 32'd128);
    run_op(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    check_eq("const_max", 32'(out), 32'h1FC02);

    // Reset during MULT must abort and clear the held result.
    @(negedge clk);
    start = 1'b1;
    row0 = 8'h33; row1 = 8'h44; col0 = 8'h55; col1 = 8'h66;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    #1;
    check_eq("abort_out", 32'(out), 32'd0);
    check_eq("abort_complete", 32'(complete), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_stays_idle", 32'(complete), 32'd0);
    run_op(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(3))
          0:       v[k] = 8'hFF;
          1:       v[k] = 8'h00;
          default: v[k] = 8'($urandom);
        endcase
      end
      run_op(v[0], v[1], v[2], v[3], 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
